// File: rtl/mac_acc_stage_if.sv
// Handshake bundle between the product combiner, the accumulate stage and
// the frame-result consumer. The master side feeds product beats and takes
// frame results; the slave side is the accumulate stage itself.
interface mac_acc_stage_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_prod, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_prod, in_first, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, out_count
    );
endinterface

// File: rtl/mac_acc_stage.sv
// Frame accumulator closing the multiply -> combine -> accumulate path.
// Sums unsigned products per frame and holds the result until taken.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no frame open; next accepted beat starts a frame
// ACC    | frame open; beats add into the running sum, bubbles allowed
// HOLD   | frame closed; result presented until the consumer takes it
module mac_acc_stage #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter bit SAT_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    mac_acc_stage_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             beat_acc;
    logic             restart;
    logic [ACC_W:0]   sum_w;

    assign beat_acc = bus.in_valid & in_ready_w;
    // An idle beat always opens a frame; in_first mid-frame drops the partial sum.
    assign restart  = beat_acc & ((state_q == S_IDLE) | bus.in_first);
    assign sum_w    = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bus.in_prod);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) begin
                    state_d = bus.in_last ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                in_ready_w = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Running sum, beat count and sticky overflow; untouched outside accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (restart) begin
            acc_q <= ACC_W'(bus.in_prod);
            cnt_q <= CNT_W'(1);
            ovf_q <= 1'b0;
        end else if (beat_acc) begin
            if (sum_w[ACC_W]) begin
                ovf_q <= 1'b1;
                acc_q <= SAT_EN ? ACC_MAX : sum_w[ACC_W-1:0];
            end else begin
                acc_q <= sum_w[ACC_W-1:0];
            end
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_acc   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_acc_stage.sv
// Bench for mac_acc_stage: three instances share one stimulus stream
// (40-bit saturating, 34-bit saturating, 34-bit wrapping with a 3-bit
// counter) and are compared against an unbounded-sum frame model.
module tb_mac_acc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_prod;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_acc_stage_if #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) if_m ();
    mac_acc_stage_if #(.PROD_W(32), .ACC_W(34), .CNT_W(16)) if_s ();
    mac_acc_stage_if #(.PROD_W(32), .ACC_W(34), .CNT_W(3))  if_w ();

    assign if_m.in_valid  = in_valid;
    assign if_m.in_prod   = in_prod;
    assign if_m.in_first  = in_first;
    assign if_m.in_last   = in_last;
    assign if_m.out_ready = out_ready;
    assign if_s.in_valid  = in_valid;
    assign if_s.in_prod   = in_prod;
    assign if_s.in_first  = in_first;
    assign if_s.in_last   = in_last;
    assign if_s.out_ready = out_ready;
    assign if_w.in_valid  = in_valid;
    assign if_w.in_prod   = in_prod;
    assign if_w.in_first  = in_first;
    assign if_w.in_last   = in_last;
    assign if_w.out_ready = out_ready;

    mac_acc_stage #(.PROD_W(32), .ACC_W(40), .SAT_EN(1'b1), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .bus(if_m.slave));
    mac_acc_stage #(.PROD_W(32), .ACC_W(34), .SAT_EN(1'b1), .CNT_W(16)) u_sat (
        .clk(clk), .rst(rst), .bus(if_s.slave));
    mac_acc_stage #(.PROD_W(32), .ACC_W(34), .SAT_EN(1'b0), .CNT_W(3)) u_wrap (
        .clk(clk), .rst(rst), .bus(if_w.slave));

    // Reference model: exact frame sum and beat count, bounded only when compared.
    logic [63:0] m_sum;
    int          m_n;
    bit          m_in_frame;

    function automatic logic [63:0] m_acc(input int w, input bit sat);
        logic [63:0] lim;
        lim = 64'd1 << w;
        if (m_sum >= lim) return sat ? (lim - 64'd1) : (m_sum & (lim - 64'd1));
        return m_sum;
    endfunction

    function automatic logic [63:0] m_ovf(input int w);
        return (m_sum >= (64'd1 << w)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] m_cnt(input int cw);
        logic [63:0] lim;
        lim = (64'd1 << cw) - 64'd1;
        return (64'(m_n) > lim) ? lim : 64'(m_n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] p, input bit f, input bit l, input int bubbles);
        bit ok;
        in_valid = 1'b0;
        repeat (bubbles) tick();
        in_prod  = p;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (if_m.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            timeout("beat_accept");
            return;
        end
        if (!m_in_frame || f) begin
            m_sum = 64'(p);
            m_n   = 1;
        end else begin
            m_sum = m_sum + 64'(p);
            m_n   = m_n + 1;
        end
        m_in_frame = !l;
        if (l) check("latency_out_valid", 64'(if_m.out_valid), 64'd1);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_acc_m"}, 64'(if_m.out_acc),   m_acc(40, 1'b1));
        check({tag, "_ovf_m"}, 64'(if_m.out_ovf),   m_ovf(40));
        check({tag, "_cnt_m"}, 64'(if_m.out_count), m_cnt(16));
        check({tag, "_acc_s"}, 64'(if_s.out_acc),   m_acc(34, 1'b1));
        check({tag, "_ovf_s"}, 64'(if_s.out_ovf),   m_ovf(34));
        check({tag, "_acc_w"}, 64'(if_w.out_acc),   m_acc(34, 1'b0));
        check({tag, "_ovf_w"}, 64'(if_w.out_ovf),   m_ovf(34));
        check({tag, "_cnt_w"}, 64'(if_w.out_count), m_cnt(3));
    endtask

    task automatic get_result(input int hold_cycles, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_m.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            timeout({tag, "_out_valid"});
            return;
        end
        check_model(tag);
        out_ready = 1'b0;
        repeat (hold_cycles) tick();
        if (hold_cycles > 0) begin
            check({tag, "_hold_valid"}, 64'(if_m.out_valid), 64'd1);
            check({tag, "_hold_acc"},   64'(if_m.out_acc),   m_acc(40, 1'b1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(if_m.out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(if_m.in_ready),  64'd1);
    endtask

    typedef struct {
        logic [31:0] prod;
        bit          first;
        bit          last;
        logic [63:0] exp_acc;
        logic [63:0] exp_cnt;
        logic [63:0] exp_ovf;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{32'd1,         1'b1, 1'b0, 64'd0,           64'd0, 64'd0};
        tbl[1] = '{32'd2,         1'b0, 1'b0, 64'd0,           64'd0, 64'd0};
        tbl[2] = '{32'd3,         1'b0, 1'b0, 64'd0,           64'd0, 64'd0};
        tbl[3] = '{32'd4,         1'b0, 1'b1, 64'd10,          64'd4, 64'd0};
        tbl[4] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF,   64'd1, 64'd0};
        tbl[5] = '{32'd7,         1'b1, 1'b0, 64'd0,           64'd0, 64'd0};
        tbl[6] = '{32'd9,         1'b0, 1'b0, 64'd0,           64'd0, 64'd0};
        tbl[7] = '{32'd5,         1'b1, 1'b0, 64'd0,           64'd0, 64'd0};
        tbl[8] = '{32'd6,         1'b0, 1'b1, 64'd11,          64'd2, 64'd0};

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_prod = '0;
        m_sum = '0; m_n = 0; m_in_frame = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 64'(if_m.out_valid), 64'd0);
        check("rst_in_ready",  64'(if_m.in_ready),  64'd1);
        check("rst_out_acc",   64'(if_m.out_acc),   64'd0);
        check("rst_out_count", 64'(if_m.out_count), 64'd0);
        check("rst_out_ovf",   64'(if_m.out_ovf),   64'd0);

        // Directed frames from the table.
        for (int i = 0; i < 9; i++) begin
            send_beat(tbl[i].prod, tbl[i].first, tbl[i].last, 0);
            if (tbl[i].last) begin
                check($sformatf("tbl%0d_acc", i), 64'(if_m.out_acc),   tbl[i].exp_acc);
                check($sformatf("tbl%0d_cnt", i), 64'(if_m.out_count), tbl[i].exp_cnt);
                check($sformatf("tbl%0d_ovf", i), 64'(if_m.out_ovf),   tbl[i].exp_ovf);
                get_result(0, $sformatf("tbl%0d", i));
            end
        end

        // Five all-ones beats: saturate vs wrap at 34 bits.
        for (int b = 0; b < 5; b++) send_beat(32'hFFFF_FFFF, b == 0, b == 4, 0);
        check("sat34_acc",  64'(if_s.out_acc),   64'h3_FFFF_FFFF);
        check("sat34_ovf",  64'(if_s.out_ovf),   64'd1);
        check("wrap34_acc", 64'(if_w.out_acc),   64'h0_FFFF_FFFB);
        check("wrap34_ovf", 64'(if_w.out_ovf),   64'd1);
        check("main40_acc", 64'(if_m.out_acc),   64'h4_FFFF_FFFB);
        check("main40_ovf", 64'(if_m.out_ovf),   64'd0);
        get_result(0, "ovf");

        // Beat counter saturation on the 3-bit instance.
        for (int b = 0; b < 9; b++) send_beat(32'd1, b == 0, b == 8, b % 2);
        check("cntsat_w",  64'(if_w.out_count), 64'd7);
        check("cntsat_m",  64'(if_m.out_count), 64'd9);
        get_result(0, "cntsat");

        // Result held with out_ready low; incoming beats must be refused.
        send_beat(32'h10, 1'b1, 1'b0, 0);
        send_beat(32'h20, 1'b0, 1'b1, 1);
        in_prod = 32'hDEAD; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d_in_ready", c), 64'(if_m.in_ready),  64'd0);
            check($sformatf("hold%0d_acc", c),      64'(if_m.out_acc),   64'h30);
            check($sformatf("hold%0d_valid", c),    64'(if_m.out_valid), 64'd1);
        end
        in_valid = 1'b0;
        get_result(0, "hold");

        // Reset mid-frame aborts it without a result.
        send_beat(32'd100, 1'b1, 1'b0, 0);
        send_beat(32'd200, 1'b0, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_in_frame = 1'b0;
        check("abort_acc",   64'(if_m.out_acc),   64'd0);
        check("abort_count", 64'(if_m.out_count), 64'd0);
        repeat (3) begin
            tick();
            check("abort_no_valid", 64'(if_m.out_valid), 64'd0);
        end
        send_beat(32'd3, 1'b1, 1'b0, 0);
        send_beat(32'd4, 1'b0, 1'b1, 0);
        check("after_abort_acc", 64'(if_m.out_acc),   64'd7);
        check("after_abort_cnt", 64'(if_m.out_count), 64'd2);
        get_result(0, "after_abort");

        // Random frames with bubbles, mid-frame restarts and slow consumers.
        for (int fr = 0; fr < 40; fr++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                logic [31:0] p;
                bit          f;
                p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                f = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
                send_beat(p, f, b == len - 1, int'($urandom_range(0, 2)));
            end
            get_result(int'($urandom_range(0, 3)), $sformatf("rnd%0d", fr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
